fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops DWIDTH-bit words from an upstream FIFO and sends each one
//               on an 8N1 serial line. Bytes go out least-significant byte
//               first and bits least-significant bit first. Every bit lasts
//               CLKDIV clock cycles. The bytes of one word follow each other
//               with no idle gap.
//
// Parameters  : DWIDTH     - FIFO word width in bits (a multiple of 8, >= 8)
//               CLKDIV     - clk_i cycles per serial bit (>= 2)
//
// Ports       : clk_i      - clock, rising edge
//               rst_i      - synchronous active-high reset
//               fifo_empty - upstream FIFO holds no word
//               fifo_data  - upstream FIFO head word
//               fifo_pop   - one-cycle pop strobe (combinational)
//               txd        - serial output, idle high (registered)
//               busy       - a word is being serialized (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DWIDTH = 32,
    parameter int CLKDIV = 868
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              txd,
    output logic              busy
);

    localparam int c_NBYTES = DWIDTH / 8;
    localparam int c_CNT_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int c_BYTE_W = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(CLKDIV - 1);
    localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(c_NBYTES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bit;
    logic [c_BYTE_W-1:0] r_byte;
    logic [DWIDTH-1:0]   r_shift;
    logic                r_txd;
    logic                r_busy;

    logic                w_pop;
    logic                w_bit_end;

    // The pop is gated by reset so that a non-empty FIFO cannot lose a word
    // while the block is held in reset.
    assign w_pop     = (r_state == c_ST_IDLE) && !fifo_empty && !rst_i;
    assign w_bit_end = (r_cnt == c_CNT_LAST);

    assign fifo_pop = w_pop;
    assign txd      = r_txd;
    assign busy     = r_busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        // The start bit goes out from the very next cycle.
                        r_shift <= fifo_data;
                        r_bit   <= '0;
                        r_byte  <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // The eighth shift of a byte brings the next byte's
                        // LSB into bit 0, ready for the next START.
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
                            r_txd   <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte == c_BYTE_LAST) begin
                            r_byte  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_byte  <= r_byte + 1'b1;
                            r_txd   <= 1'b0;
                            r_state <= c_ST_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx (DWIDTH=32, CLKDIV=4).
//               It applies table-driven single words and then runs
//               hand-written sequences for reset, an empty FIFO, back-to-back
//               words, a data change after capture, and reset mid-word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_DW  = 32;
    localparam int c_DIV = 4;

    logic            clk_i;
    logic            rst_i;
    logic            fifo_empty;
    logic [c_DW-1:0] fifo_data;
    logic            fifo_pop;
    logic            txd;
    logic            busy;

    int n_checks;
    int n_errors;
    int pop_cnt;
    int cyc;

    typedef struct {
        logic [31:0]     word;
        logic [3:0][7:0] bytes;   // bytes[0] is the first byte on the line
    } vec_t;

    vec_t vecs [4];

    fifo_uart_tx #(
        .DWIDTH (c_DW),
        .CLKDIV (c_DIV)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (fifo_pop === 1'b1) pop_cnt <= pop_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge while the DUT is idle: presents a word and checks
    // that the pop strobe is raised in that same cycle.
    task automatic start_word(input logic [31:0] w);
        fifo_data  = w;
        fifo_empty = 1'b0;
        #1;
        chk("pop_cycle_pop",  {31'd0, fifo_pop}, 32'd1);
        chk("pop_cycle_busy", {31'd0, busy},     32'd0);
        chk("pop_cycle_txd",  {31'd0, txd},      32'd1);
    endtask

    // Checks every cycle of a 4-byte frame sequence starting on the cycle
    // after the pop. The FIFO inputs are changed to nxt_* on the first cycle.
    task automatic expect_word(input string tag, input logic [3:0][7:0] bytes,
                               input logic nxt_empty, input logic [31:0] nxt_data);
        logic exp_bit;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < c_DIV; c++) begin
                    @(negedge clk_i);
                    if (b == 0 && k == 0 && c == 0) begin
                        fifo_empty = nxt_empty;
                        fifo_data  = nxt_data;
                    end
                    #1;
                    if (k == 0)      exp_bit = 1'b0;
                    else if (k == 9) exp_bit = 1'b1;
                    else             exp_bit = bytes[b][k-1];
                    chk({tag, "_txd"},  {31'd0, txd},      {31'd0, exp_bit});
                    chk({tag, "_busy"}, {31'd0, busy},     32'd1);
                    chk({tag, "_pop"},  {31'd0, fifo_pop}, 32'd0);
                end
            end
        end
    endtask

    initial begin
        int pop_base;
        int start_cyc;

        n_checks = 0;
        n_errors = 0;
        pop_cnt  = 0;
        cyc      = 0;

        vecs[0] = '{word: 32'h44332211, bytes: {8'h44, 8'h33, 8'h22, 8'h11}};
        vecs[1] = '{word: 32'h000000FF, bytes: {8'h00, 8'h00, 8'h00, 8'hFF}};
        vecs[2] = '{word: 32'h80000001, bytes: {8'h80, 8'h00, 8'h00, 8'h01}};
        vecs[3] = '{word: 32'hC3A50F96, bytes: {8'hC3, 8'hA5, 8'h0F, 8'h96}};

        // Reset held for 3 cycles with a non-empty FIFO.
        rst_i      = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("rst_pop",  {31'd0, fifo_pop}, 32'd0);
            chk("rst_txd",  {31'd0, txd},      32'd1);
            chk("rst_busy", {31'd0, busy},     32'd0);
        end

        // Empty FIFO for 100 cycles: stays idle.
        @(negedge clk_i);
        rst_i      = 1'b0;
        fifo_empty = 1'b1;
        pop_base   = pop_cnt;
        repeat (100) begin
            @(negedge clk_i);
            #1;
            chk("empty_pop",  {31'd0, fifo_pop}, 32'd0);
            chk("empty_txd",  {31'd0, txd},      32'd1);
            chk("empty_busy", {31'd0, busy},     32'd0);
        end
        chk("empty_pop_count", pop_cnt - pop_base, 32'd0);

        // Table-driven single words.
        for (int v = 0; v < 4; v++) begin
            pop_base = pop_cnt;
            @(negedge clk_i);
            start_word(vecs[v].word);
            expect_word("vec", vecs[v].bytes, 1'b1, 32'h0);
            @(negedge clk_i);
            #1;
            chk("vec_end_busy", {31'd0, busy}, 32'd0);
            chk("vec_end_txd",  {31'd0, txd},  32'd1);
            chk("vec_pop_count", pop_cnt - pop_base, 32'd1);
        end

        // Two queued words: one idle (pop) cycle between them, 321 cycles.
        pop_base = pop_cnt;
        @(negedge clk_i);
        start_word(32'hA5A5A5A5);
        start_cyc = cyc + 1;
        expect_word("b2b_w0", {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 1'b0, 32'h0000FF00);
        @(negedge clk_i);
        #1;
        chk("b2b_gap_pop",  {31'd0, fifo_pop}, 32'd1);
        chk("b2b_gap_busy", {31'd0, busy},     32'd0);
        chk("b2b_gap_txd",  {31'd0, txd},      32'd1);
        expect_word("b2b_w1", {8'h00, 8'h00, 8'hFF, 8'h00}, 1'b1, 32'h0);
        chk("b2b_total_cycles", cyc - start_cyc + 1, 32'd321);
        @(negedge clk_i);
        #1;
        chk("b2b_end_busy", {31'd0, busy}, 32'd0);
        chk("b2b_pop_count", pop_cnt - pop_base, 32'd2);

        // Data changed after capture does not disturb the word in flight.
        pop_base = pop_cnt;
        @(negedge clk_i);
        start_word(32'h12345678);
        expect_word("hold", {8'h12, 8'h34, 8'h56, 8'h78}, 1'b1, 32'hDEADBEEF);
        @(negedge clk_i);
        #1;
        chk("hold_end_busy", {31'd0, busy}, 32'd0);
        chk("hold_pop_count", pop_cnt - pop_base, 32'd1);

        // Reset during bit 3 of byte 1 (0x22, bit 3 = 0): cycles 57..60.
        pop_base = pop_cnt;
        @(negedge clk_i);
        start_word(32'h44332211);
        repeat (58) @(negedge clk_i);
        #1;
        chk("midrst_pre_txd",  {31'd0, txd},  32'd0);
        chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
        rst_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("midrst_txd",  {31'd0, txd},      32'd1);
            chk("midrst_busy", {31'd0, busy},     32'd0);
            chk("midrst_pop",  {31'd0, fifo_pop}, 32'd0);
        end
        rst_i      = 1'b0;
        fifo_empty = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            #1;
            chk("post_rst_txd",  {31'd0, txd},  32'd1);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        chk("midrst_pop_count", pop_cnt - pop_base, 32'd1);

        // First pop right after reset release.
        @(negedge clk_i);
        start_word(32'h000000FF);
        expect_word("after_rst", {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
